// File: rtl/ski_heap_alloc_arbiter_if.sv
// rtl/ski_heap_alloc_arbiter_if.sv - requester, response and heap write port bundle for the heap allocator arbiter
interface ski_heap_alloc_arbiter_if;
    logic        req0_valid;
    logic [62:0] req0_term;
    logic        req0_ready;
    logic        req1_valid;
    logic [62:0] req1_term;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [29:0] rsp_addr;
    logic        rsp_err;
    logic        mem_wr_en;
    logic [29:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic        mem_wr_ack;
    logic        heap_rewind;
    logic        heap_full;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_term, req1_valid, req1_term, mem_wr_ack, heap_rewind,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_addr, rsp_err,
               mem_wr_en, mem_wr_addr, mem_wr_data, heap_full
    );

    // Requester / heap / GC side
    modport master (
        output req0_valid, req0_term, req1_valid, req1_term, mem_wr_ack, heap_rewind,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_addr, rsp_err,
               mem_wr_en, mem_wr_addr, mem_wr_data, heap_full
    );
endinterface

// File: rtl/ski_heap_alloc_arbiter.sv
// rtl/ski_heap_alloc_arbiter.sv - round-robin heap write arbiter with SKI term encoder and bump allocator
module ski_heap_alloc_arbiter #(
    parameter logic [29:0] HEAP_BASE  = 30'd0,
    parameter logic [29:0] HEAP_LIMIT = 30'd1023
) (
    input  logic                           system1000,
    input  logic                           system1000_rstn,
    ski_heap_alloc_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    // One past the last usable address; the pointer carries an extra bit so this never wraps.
    localparam logic [30:0] FULL_PTR = {1'b0, HEAP_LIMIT} + 31'd1;
    localparam logic [30:0] BASE_PTR = {1'b0, HEAP_BASE};

    state_t      state_q, state_d;
    logic [30:0] ptr_q, ptr_d;
    logic        full_q, full_d;
    logic        last_grant_q, last_grant_d;
    logic        rewind_pend_q, rewind_pend_d;
    logic        id_q, id_d;
    logic        err_q, err_d;
    logic [29:0] addr_q, addr_d;
    logic [63:0] word_q, word_d;
    logic        gnt;

    // Map a 63-bit SKI term onto the 64-bit heap word: combinators carry only a tag,
    // applications keep both 30-bit child pointers, literals keep a 32-bit payload.
    function automatic logic [63:0] encode(input logic [62:0] term);
        logic [63:0] w;
        casez (term[62:60])
            3'b000:  w = {4'h0, 60'd0};
            3'b001:  w = {4'h1, 60'd0};
            3'b010:  w = {4'h2, 60'd0};
            3'b011:  w = {4'h3, term[59:30], term[29:0]};
            default: w = {4'h4, 28'd0, term[59:28]};
        endcase
        return w;
    endfunction

    // State, allocator and latched transaction registers
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q       <= IDLE;
            ptr_q         <= BASE_PTR;
            full_q        <= 1'b0;
            last_grant_q  <= 1'b1;
            rewind_pend_q <= 1'b0;
            id_q          <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= 30'd0;
            word_q        <= 64'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            full_q        <= full_d;
            last_grant_q  <= last_grant_d;
            rewind_pend_q <= rewind_pend_d;
            id_q          <= id_d;
            err_q         <= err_d;
            addr_q        <= addr_d;
            word_q        <= word_d;
        end
    end

    // Next-state, arbitration and handshake outputs
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        last_grant_d   = last_grant_q;
        rewind_pend_d  = rewind_pend_q;
        id_d           = id_q;
        err_d          = err_q;
        addr_d         = addr_q;
        word_d         = word_q;
        gnt            = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp_addr   = 30'd0;
        bus.rsp_err    = 1'b0;
        bus.mem_wr_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rewind_pend_q || bus.heap_rewind) begin
                    // The rewind cycle grants nothing so the new base is used by the next term.
                    ptr_d         = BASE_PTR;
                    rewind_pend_d = 1'b0;
                end else if (bus.req0_valid || bus.req1_valid) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        gnt = ~last_grant_q;
                    end else begin
                        gnt = bus.req1_valid;
                    end
                    bus.req0_ready = ~gnt;
                    bus.req1_ready = gnt;
                    word_d         = encode(gnt ? bus.req1_term : bus.req0_term);
                    id_d           = gnt;
                    addr_d         = ptr_q[29:0];
                    err_d          = full_q;
                    state_d        = full_q ? DONE : WRITE;
                end
            end
            WRITE: begin
                bus.mem_wr_en = 1'b1;
                if (bus.heap_rewind) begin
                    rewind_pend_d = 1'b1;
                end
                if (bus.mem_wr_ack) begin
                    ptr_d   = ptr_q + 31'd1;
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.rsp0_valid = ~id_q;
                bus.rsp1_valid = id_q;
                bus.rsp_addr   = err_q ? 30'd0 : addr_q;
                bus.rsp_err    = err_q;
                last_grant_d   = id_q;
                if (bus.heap_rewind) begin
                    rewind_pend_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        full_d = (ptr_d == FULL_PTR);
    end

    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = word_q;
    assign bus.heap_full   = full_q;
endmodule

// File: tb/tb_ski_heap_alloc_arbiter.sv
// tb/tb_ski_heap_alloc_arbiter.sv - scoreboard bench for the heap allocator arbiter
module tb_ski_heap_alloc_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0v = 1'b0, r1v = 1'b0;
    logic [62:0] r0t = '0, r1t = '0;
    logic        ack = 1'b0, hrw = 1'b0;
    bit          sel = 1'b0;
    bit          ack_hold = 1'b0, ack_force = 1'b0;
    int          ack_dly = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          errors = 0, checks = 0;

    ski_heap_alloc_arbiter_if bus_a();
    ski_heap_alloc_arbiter_if bus_b();

    ski_heap_alloc_arbiter dut_a (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .bus             (bus_a)
    );

    ski_heap_alloc_arbiter #(.HEAP_BASE(30'd0), .HEAP_LIMIT(30'd2)) dut_b (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .bus             (bus_b)
    );

    assign bus_a.req0_valid = r0v;  assign bus_b.req0_valid = r0v;
    assign bus_a.req0_term  = r0t;  assign bus_b.req0_term  = r0t;
    assign bus_a.req1_valid = r1v;  assign bus_b.req1_valid = r1v;
    assign bus_a.req1_term  = r1t;  assign bus_b.req1_term  = r1t;
    assign bus_a.mem_wr_ack = ack;  assign bus_b.mem_wr_ack = ack;
    assign bus_a.heap_rewind = hrw; assign bus_b.heap_rewind = hrw;

    logic        o_r0, o_r1, o_rsp0, o_rsp1, o_err, o_wr_en, o_full;
    logic [29:0] o_rsp_addr, o_wr_addr;
    logic [63:0] o_wr_data;
    assign o_r0       = sel ? bus_b.req0_ready  : bus_a.req0_ready;
    assign o_r1       = sel ? bus_b.req1_ready  : bus_a.req1_ready;
    assign o_rsp0     = sel ? bus_b.rsp0_valid  : bus_a.rsp0_valid;
    assign o_rsp1     = sel ? bus_b.rsp1_valid  : bus_a.rsp1_valid;
    assign o_rsp_addr = sel ? bus_b.rsp_addr    : bus_a.rsp_addr;
    assign o_err      = sel ? bus_b.rsp_err     : bus_a.rsp_err;
    assign o_wr_en    = sel ? bus_b.mem_wr_en   : bus_a.mem_wr_en;
    assign o_wr_addr  = sel ? bus_b.mem_wr_addr : bus_a.mem_wr_addr;
    assign o_wr_data  = sel ? bus_b.mem_wr_data : bus_a.mem_wr_data;
    assign o_full     = sel ? bus_b.heap_full   : bus_a.heap_full;

    typedef struct {
        int          id;
        logic [29:0] addr;
        bit          err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [29:0] addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        bit          rst_first;
        int          dly;
        bit          v0;
        logic [62:0] t0;
        bit          v1;
        logic [62:0] t1;
        int          exp_id;
        logic [29:0] exp_addr;
        logic [63:0] exp_data;
    } vec_t;

    rsp_t rspq[$];
    wr_t  wrq[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Heap model: acknowledge each write ack_dly cycles after mem_wr_en rises
    always @(posedge clk) begin
        #1;
        if (ack_force) begin
            ack = 1'b1;
        end else if (ack_hold || !o_wr_en) begin
            ack  = 1'b0;
            wcnt = 0;
        end else if (wcnt >= ack_dly) begin
            ack  = 1'b1;
            wcnt = 0;
        end else begin
            ack = 1'b0;
            wcnt++;
        end
    end

    // Scoreboard: compare heap writes and responses against queued expectations
    always @(negedge clk) begin : mon
        rsp_t e;
        if (o_wr_en) begin
            checks++;
            if (wrq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%h", o_wr_addr, o_wr_data);
            end else begin
                if (o_wr_addr !== wrq[0].addr || o_wr_data !== wrq[0].data) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%h expected addr=%0h data=%h",
                             o_wr_addr, o_wr_data, wrq[0].addr, wrq[0].data);
                end
                if (ack) void'(wrq.pop_front());
            end
        end
        if (o_rsp0 || o_rsp1) begin
            checks++;
            if (rspq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp rsp0=%0b rsp1=%0b addr=%0h err=%0b", o_rsp0, o_rsp1, o_rsp_addr, o_err);
            end else begin
                e = rspq.pop_front();
                if ((o_rsp0 && o_rsp1) || (o_rsp1 != (e.id == 1)) || o_rsp_addr !== e.addr ||
                    o_err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL response got id=%0d addr=%0h err=%0b cyc=%0d expected id=%0d addr=%0h err=%0b cyc=%0d",
                             o_rsp1 ? 1 : 0, o_rsp_addr, o_err, cyc, e.id, e.addr, e.err, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        r0v = 1'b0; r1v = 1'b0; hrw = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wrq.delete();
        rspq.delete();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (wrq.size() == 0 && rspq.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_outstanding", 64'(wrq.size() + rspq.size()), 64'd0);
    endtask

    // Present a request (caller is at posedge+1), wait for the grant, queue expectations.
    task automatic do_req(input bit v0, input logic [62:0] t0, input bit v1, input logic [62:0] t1,
                          input int exp_id, input logic [29:0] exp_addr, input logic [63:0] exp_data,
                          input bit exp_err, input bit hold, output int acc);
        bit got = 1'b0;
        r0v = v0; r0t = t0; r1v = v1; r1t = t1;
        acc = cyc;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (o_r0 || o_r1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
            r0v = 1'b0; r1v = 1'b0;
            return;
        end
        chk("grant_onehot", {62'd0, o_r1, o_r0}, (exp_id == 1) ? 64'd2 : 64'd1);
        acc = cyc;
        rspq.push_back('{id: exp_id, addr: exp_addr, err: exp_err,
                         cyc: acc + (exp_err ? 1 : ack_dly + 2)});
        if (!exp_err) wrq.push_back('{addr: exp_addr, data: exp_data});
        @(posedge clk); #1;
        if (!hold) begin r0v = 1'b0; r1v = 1'b0; end
        r0t = 63'({$urandom(), $urandom()});
        r1t = 63'({$urandom(), $urandom()});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int acc, prev;
        logic [62:0] t0, t1;

        vecs[0] = '{1'b1, 2, 1'b1, {3'b011, 30'd5, 30'd9}, 1'b0, 63'd0, 0, 30'd0, 64'h3000_0001_4000_0009};
        vecs[1] = '{1'b1, 0, 1'b1, {3'b000, 60'h123_4567_89AB_CDEF}, 1'b0, 63'd0, 0, 30'd0, 64'h0000_0000_0000_0000};
        vecs[2] = '{1'b0, 0, 1'b1, {3'b001, 60'h123_4567_89AB_CDEF}, 1'b0, 63'd0, 0, 30'd1, 64'h1000_0000_0000_0000};
        vecs[3] = '{1'b0, 0, 1'b1, {3'b010, 60'h123_4567_89AB_CDEF}, 1'b0, 63'd0, 0, 30'd2, 64'h2000_0000_0000_0000};
        vecs[4] = '{1'b0, 0, 1'b1, {3'b100, 32'hDEAD_BEEF, 28'h5A5_A5A5}, 1'b0, 63'd0, 0, 30'd3, 64'h4000_0000_DEAD_BEEF};
        vecs[5] = '{1'b0, 0, 1'b0, 63'd0, 1'b1, {3'b111, 32'h0123_4567, 28'hFFF_FFFF}, 1, 30'd4, 64'h4000_0000_0123_4567};
        vecs[6] = '{1'b0, 0, 1'b1, {3'b011, 30'h3FFF_FFFF, 30'd0}, 1'b1, {3'b010, 60'd1}, 0, 30'd5, 64'h3FFF_FFFF_C000_0000};

        // Reset values of both instances
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            chk("rst_ready", {62'd0, o_r1, o_r0}, 64'd0);
            chk("rst_rsp", {61'd0, o_rsp1, o_rsp0, o_err}, 64'd0);
            chk("rst_rsp_addr", 64'(o_rsp_addr), 64'd0);
            chk("rst_wr_en", 64'(o_wr_en), 64'd0);
            chk("rst_wr_addr", 64'(o_wr_addr), 64'd0);
            chk("rst_wr_data", o_wr_data, 64'd0);
            chk("rst_heap_full", 64'(o_full), 64'd0);
        end
        sel = 1'b0;

        // Single request and encoding sweep
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rst_first) reset_dut();
            ack_dly = vecs[i].dly;
            do_req(vecs[i].v0, vecs[i].t0, vecs[i].v1, vecs[i].t1, vecs[i].exp_id,
                   vecs[i].exp_addr, vecs[i].exp_data, 1'b0, 1'b0, acc);
            drain();
            if (i == 0) chk("single_heap_full", 64'(o_full), 64'd0);
        end

        // Round-robin with both requesters always valid
        reset_dut();
        ack_dly = 0;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            t0 = {3'b011, 30'(i), 30'd100};
            t1 = {3'b011, 30'(i), 30'd200};
            do_req(1'b1, t0, 1'b1, t1, i % 2, 30'(i),
                   {4'h3, 30'(i), (i % 2 == 1) ? 30'd200 : 30'd100}, 1'b0, 1'b1, acc);
            if (i > 0) chk("accept_spacing", 64'(acc - prev), 64'd3);
            prev = acc;
        end
        r0v = 1'b0; r1v = 1'b0;
        drain();

        // Rewind during the write of address 4, then stray acks while idle
        reset_dut();
        ack_dly = 0;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, {3'b011, 30'(i), 30'h155}, 1'b0, 63'd0, 0, 30'(i),
                   {4'h3, 30'(i), 30'h155}, 1'b0, 1'b0, acc);
        end
        drain();
        ack_dly = 3;
        do_req(1'b1, {3'b011, 30'd4, 30'h155}, 1'b0, 63'd0, 0, 30'd4,
               {4'h3, 30'd4, 30'h155}, 1'b0, 1'b0, acc);
        hrw = 1'b1;
        @(posedge clk); #1;
        hrw = 1'b0;
        drain();
        #2 ack_force = 1'b1;
        repeat (2) @(posedge clk);
        #2 ack_force = 1'b0;
        @(posedge clk); #1;
        ack_dly = 0;
        do_req(1'b1, {3'b011, 30'd9, 30'd1}, 1'b0, 63'd0, 0, 30'd0,
               {4'h3, 30'd9, 30'd1}, 1'b0, 1'b0, acc);
        drain();

        // Exhaustion on the three-entry heap
        sel = 1'b1;
        reset_dut();
        ack_dly = 0;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 63'd0, 1'b1, {3'b011, 30'(i + 7), 30'(i)}, 1, 30'(i),
                   {4'h3, 30'(i + 7), 30'(i)}, 1'b0, 1'b0, acc);
            drain();
            chk("exh_heap_full", 64'(o_full), (i == 2) ? 64'd1 : 64'd0);
        end
        do_req(1'b0, 63'd0, 1'b1, {3'b011, 30'd3, 30'd3}, 1, 30'd0, 64'd0, 1'b1, 1'b0, acc);
        drain();
        chk("exh_full_after_err", 64'(o_full), 64'd1);
        hrw = 1'b1;
        @(posedge clk); #1;
        hrw = 1'b0;
        chk("rewind_clears_full", 64'(o_full), 64'd0);
        do_req(1'b0, 63'd0, 1'b1, {3'b001, 60'd5}, 1, 30'd0, 64'h1000_0000_0000_0000, 1'b0, 1'b0, acc);
        drain();

        // Asynchronous reset while a write waits for its ack
        sel = 1'b0;
        reset_dut();
        ack_hold = 1'b1;
        do_req(1'b1, {3'b011, 30'd1, 30'd2}, 1'b0, 63'd0, 0, 30'd0,
               {4'h3, 30'd1, 30'd2}, 1'b0, 1'b0, acc);
        chk("midwr_wr_en_high", 64'(o_wr_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midwr_wr_en_async_drop", 64'(o_wr_en), 64'd0);
        wrq.delete();
        rspq.delete();
        ack_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        ack_dly = 0;
        do_req(1'b1, {3'b011, 30'd6, 30'd6}, 1'b1, {3'b011, 30'd7, 30'd7}, 0, 30'd0,
               {4'h3, 30'd6, 30'd6}, 1'b0, 1'b0, acc);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
